cam_fb_ctrl: RTL

Frame-capture controller and port arbiter for the camera frame buffer RAM in the `wb_camera` peripheral. It sequences one frame of pixels from the synchronized camera stream into the buffer on host command. It also shares the buffer's single address bus between camera writes and host (Wishbone-side) reads. Camera writes always win; host reads fill idle cycles.

---
 rtl/cam_fb_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cam_fb_ctrl.sv
// rtl/cam_fb_ctrl.sv - frame capture sequencer and camera/host arbiter for the frame buffer RAM
module cam_fb_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DEPTH      = 120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cam_vsync,
    input  logic                  cam_href,
    input  logic                  cam_pix_valid,
    input  logic [DATA_WIDTH-1:0] cam_pix_data,
    input  logic                  host_rd_req,
    input  logic [ADDR_WIDTH-1:0] host_rd_addr,
    output logic                  host_rd_ack,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   pix_count,
    output logic [7:0]            frame_cnt
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_LAST  = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VSYNC,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_vsync_q;
    logic                  r_ack;
    logic                  r_ack_oor;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [ADDR_WIDTH:0]   r_pix_count;
    logic [7:0]            r_frame_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic w_vs_rise;
    logic w_pix_wr;
    logic w_grant;
    logic w_in_range;
    logic w_frame_end;
    logic w_clear;

    assign w_vs_rise  = cam_vsync & ~r_vsync_q;
    assign w_pix_wr   = (r_state == S_CAPTURE) & cam_href & cam_pix_valid & ~w_vs_rise;
    // An ack cycle doubles as the "read outstanding" window, so one flag covers both.
    assign w_grant    = ~w_pix_wr & host_rd_req & ~r_ack;
    assign w_in_range = ({1'b0, host_rd_addr} < LP_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_clear     = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_WAIT_VSYNC;
                        w_clear     = 1'b1;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (w_vs_rise) begin
                        w_state_nxt = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_rise || (w_pix_wr && (r_pix_count == LP_LAST))) begin
                        w_state_nxt = S_DONE;
                        w_frame_end = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_we    = w_pix_wr;
        ram_wdata = w_pix_wr ? cam_pix_data : '0;
        ram_addr  = r_addr_q;
        if (w_pix_wr) begin
            ram_addr = r_pix_count[ADDR_WIDTH-1:0];
        end else if (w_grant && w_in_range) begin
            ram_addr = host_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vsync_q   <= 1'b0;
            r_ack       <= 1'b0;
            r_ack_oor   <= 1'b0;
            r_addr_q    <= '0;
            r_pix_count <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_q <= cam_vsync;
            r_ack     <= w_grant;
            r_ack_oor <= w_grant & ~w_in_range;
            r_addr_q  <= ram_addr;
            if (w_clear) begin
                r_pix_count <= '0;
            end else if (w_pix_wr) begin
                r_pix_count <= r_pix_count + 1'b1;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            r_busy <= (w_state_nxt == S_WAIT_VSYNC) || (w_state_nxt == S_CAPTURE);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign host_rd_ack  = r_ack;
    assign host_rd_data = (r_ack && !r_ack_oor) ? ram_rdata : '0;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pix_count    = r_pix_count;
    assign frame_cnt    = r_frame_cnt;

endmodule
